// File: rtl/enc8b10b_serializer_if.sv
// Byte input handshake (valid/ready) for enc8b10b_serializer.
// ENC8B10B_KCHAR_EN adds the i_K control-character flag to the bundle.
interface enc8b10b_serializer_if;
    logic [7:0] i_Data;
    logic       i_Valid;
    logic       o_Ready;
`ifdef ENC8B10B_KCHAR_EN
    logic       i_K;
    modport master (output i_Data, i_Valid, i_K, input o_Ready);
    modport slave  (input i_Data, i_Valid, i_K, output o_Ready);
`else
    modport master (output i_Data, i_Valid, input o_Ready);
    modport slave  (input i_Data, i_Valid, output o_Ready);
`endif
endinterface

// File: rtl/enc8b10b_serializer.sv
// 8b/10b encoder + serializer with input byte FIFO and K28.5 idle fill.
// ENC8B10B_KCHAR_EN enables i_K control characters and the o_K_Err flag.
module enc8b10b_serializer #(
    parameter int SER_WIDTH  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_Clk,
    input  logic                 i_rst,
    enc8b10b_serializer_if.slave io_Bus,
    output logic [SER_WIDTH-1:0] o_Ser_Data,
    output logic [9:0]           o_10B,
    output logic                 o_RD,
    output logic                 o_Sym_Start,
    output logic                 o_Idle
`ifdef ENC8B10B_KCHAR_EN
    ,
    output logic                 o_K_Err
`endif
);

    localparam int BEATS = 10 / SER_WIDTH;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
`ifdef ENC8B10B_KCHAR_EN
    localparam int EW    = 9;
`else
    localparam int EW    = 8;
`endif

    // Returns {rd_out, abcdei fghj}; k selects the control table, unknown K codes fall back to K28.5.
    function automatic logic [10:0] encode(input logic [7:0] d, input logic k, input logic rd);
        logic [10:0] res;
        logic [9:0]  kc;
        logic [5:0]  c6;
        logic [3:0]  c4;
        logic [4:0]  x;
        logic        rd6;
        logic        a7;
        x   = d[4:0];
        kc  = 10'b0011111010;
        c6  = 6'b000000;
        c4  = 4'b0000;
        rd6 = rd;
        a7  = 1'b0;
        if (k) begin
            case (d)
                8'h1C: kc = 10'b0011110100;   8'h3C: kc = 10'b0011111001;
                8'h5C: kc = 10'b0011110101;   8'h7C: kc = 10'b0011110011;
                8'h9C: kc = 10'b0011110010;   8'hBC: kc = 10'b0011111010;
                8'hDC: kc = 10'b0011110110;   8'hFC: kc = 10'b0011111000;
                8'hF7: kc = 10'b1110101000;   8'hFB: kc = 10'b1101101000;
                8'hFD: kc = 10'b1011101000;   8'hFE: kc = 10'b0111101000;
                default: kc = 10'b0011111010;
            endcase
            res = {rd ^ ($countones(kc) != 5), rd ? ~kc : kc};
        end else begin
            case (x)
                5'd0:  c6 = 6'b100111;  5'd1:  c6 = 6'b011101;  5'd2:  c6 = 6'b101101;  5'd3:  c6 = 6'b110001;
                5'd4:  c6 = 6'b110101;  5'd5:  c6 = 6'b101001;  5'd6:  c6 = 6'b011001;  5'd7:  c6 = 6'b111000;
                5'd8:  c6 = 6'b111001;  5'd9:  c6 = 6'b100101;  5'd10: c6 = 6'b010101;  5'd11: c6 = 6'b110100;
                5'd12: c6 = 6'b001101;  5'd13: c6 = 6'b101100;  5'd14: c6 = 6'b011100;  5'd15: c6 = 6'b010111;
                5'd16: c6 = 6'b011011;  5'd17: c6 = 6'b100011;  5'd18: c6 = 6'b010011;  5'd19: c6 = 6'b110010;
                5'd20: c6 = 6'b001011;  5'd21: c6 = 6'b101010;  5'd22: c6 = 6'b011010;  5'd23: c6 = 6'b111010;
                5'd24: c6 = 6'b110011;  5'd25: c6 = 6'b100110;  5'd26: c6 = 6'b010110;  5'd27: c6 = 6'b110110;
                5'd28: c6 = 6'b001110;  5'd29: c6 = 6'b101110;  5'd30: c6 = 6'b011110;  default: c6 = 6'b101011;
            endcase
            // D.7 is balanced but still has distinct RD-/RD+ forms, like .3 in the 3b/4b table.
            if (rd && (($countones(c6) != 3) || x == 5'd7)) c6 = ~c6;
            rd6 = rd ^ ($countones(c6) != 3);
            a7  = rd6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                      : (x == 5'd17 || x == 5'd18 || x == 5'd20);
            case (d[7:5])
                3'd0: c4 = 4'b1011;  3'd1: c4 = 4'b1001;  3'd2: c4 = 4'b0101;  3'd3: c4 = 4'b1100;
                3'd4: c4 = 4'b1101;  3'd5: c4 = 4'b1010;  3'd6: c4 = 4'b0110;
                default: c4 = a7 ? 4'b0111 : 4'b1110;
            endcase
            if (rd6 && (($countones(c4) != 2) || d[7:5] == 3'd3)) c4 = ~c4;
            res = {rd6 ^ ($countones(c4) != 2), c6, c4};
        end
        return res;
    endfunction

`ifdef ENC8B10B_KCHAR_EN
    function automatic logic validK(input logic [7:0] d);
        return (d[4:0] == 5'd28) || (d == 8'hF7) || (d == 8'hFB) || (d == 8'hFD) || (d == 8'hFE);
    endfunction
`endif

    logic [EW-1:0] r_Mem [FIFO_DEPTH];
    logic [AW-1:0] r_WrPtr, r_RdPtr;
    logic [CW-1:0] r_Count;
    logic          r_Ready, r_Active, r_RD, r_SymStart, r_Idle;
    logic [3:0]    r_Beat;
    logic [9:0]    r_Shift, r_10B;
    logic          w_Wr, w_Rd, w_Load, w_Empty, w_HeadK;
    logic [CW-1:0] w_CountNext;
    logic [EW-1:0] w_Head, w_In;
    logic [10:0]   w_Enc;
`ifdef ENC8B10B_KCHAR_EN
    logic          r_KErr;
    assign w_In    = {io_Bus.i_K, io_Bus.i_Data};
    assign w_HeadK = w_Head[8];
    assign o_K_Err = r_KErr;
`else
    assign w_In    = io_Bus.i_Data;
    assign w_HeadK = 1'b0;
`endif

    assign w_Wr        = io_Bus.i_Valid & r_Ready;
    assign w_Empty     = (r_Count == '0);
    assign w_Load      = !r_Active || (r_Beat == 4'(BEATS - 1));
    assign w_Rd        = w_Load & !w_Empty;
    assign w_Head      = r_Mem[r_RdPtr];
    assign w_Enc       = w_Empty ? encode(8'hBC, 1'b1, r_RD) : encode(w_Head[7:0], w_HeadK, r_RD);
    assign w_CountNext = r_Count + CW'(w_Wr) - CW'(w_Rd);

    assign io_Bus.o_Ready = r_Ready;
    assign o_Ser_Data     = r_Shift[9 -: SER_WIDTH];
    assign o_10B          = r_10B;
    assign o_RD           = r_RD;
    assign o_Sym_Start    = r_SymStart;
    assign o_Idle         = r_Idle;

    always_ff @(posedge i_Clk) begin
        if (w_Wr) r_Mem[r_WrPtr] <= w_In;
    end

    // r_Active is clear only straight out of reset, forcing a load on the first edge.
    always_ff @(posedge i_Clk or posedge i_rst) begin
        if (i_rst) begin
            r_WrPtr    <= '0;
            r_RdPtr    <= '0;
            r_Count    <= '0;
            r_Ready    <= 1'b0;
            r_Active   <= 1'b0;
            r_Beat     <= '0;
            r_Shift    <= '0;
            r_10B      <= '0;
            r_RD       <= 1'b0;
            r_SymStart <= 1'b0;
            r_Idle     <= 1'b0;
`ifdef ENC8B10B_KCHAR_EN
            r_KErr     <= 1'b0;
`endif
        end else begin
            r_Count    <= w_CountNext;
            r_Ready    <= (w_CountNext != CW'(FIFO_DEPTH));
            r_SymStart <= w_Load;
            if (w_Wr) r_WrPtr <= r_WrPtr + AW'(1);
            if (w_Rd) r_RdPtr <= r_RdPtr + AW'(1);
`ifdef ENC8B10B_KCHAR_EN
            r_KErr     <= w_Rd & w_HeadK & !validK(w_Head[7:0]);
`endif
            if (w_Load) begin
                r_Active <= 1'b1;
                r_Beat   <= '0;
                r_Shift  <= w_Enc[9:0];
                r_10B    <= w_Enc[9:0];
                r_RD     <= w_Enc[10];
                r_Idle   <= w_Empty;
            end else begin
                r_Beat   <= r_Beat + 4'd1;
                r_Shift  <= r_Shift << SER_WIDTH;
            end
        end
    end

endmodule

// File: tb/tb_enc8b10b_serializer.sv
// Randomized bench for enc8b10b_serializer against a running-digital-sum 8b/10b model.
// Define ENC8B10B_KCHAR_EN to also exercise control characters and o_K_Err.
module tb_enc8b10b_serializer;

    localparam int SW    = 2;
    localparam int DEPTH = 4;
    localparam int BEATS = 10 / SW;

    localparam logic [5:0] T6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [3:0] T4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};

    typedef struct {
        logic [7:0] d;
        logic       k;
        int         acc;
    } ent_t;

    logic          i_Clk = 1'b0;
    logic          i_rst = 1'b0;
    logic [SW-1:0] o_Ser_Data;
    logic [9:0]    o_10B;
    logic          o_RD, o_Sym_Start, o_Idle;
`ifdef ENC8B10B_KCHAR_EN
    logic          o_K_Err;
`endif

    enc8b10b_serializer_if bus();

    enc8b10b_serializer #(.SER_WIDTH(SW), .FIFO_DEPTH(DEPTH)) dut (
        .i_Clk       (i_Clk),
        .i_rst       (i_rst),
        .io_Bus      (bus),
        .o_Ser_Data  (o_Ser_Data),
        .o_10B       (o_10B),
        .o_RD        (o_RD),
        .o_Sym_Start (o_Sym_Start),
        .o_Idle      (o_Idle)
`ifdef ENC8B10B_KCHAR_EN
        ,
        .o_K_Err     (o_K_Err)
`endif
    );

    always #5 i_Clk = ~i_Clk;

    int nCompared   = 0;
    int nMismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [9:0] kTab(input logic [7:0] d);
        case (d)
            8'h1C: return 10'b0011110100;
            8'h3C: return 10'b0011111001;
            8'h5C: return 10'b0011110101;
            8'h7C: return 10'b0011110011;
            8'h9C: return 10'b0011110010;
            8'hBC: return 10'b0011111010;
            8'hDC: return 10'b0011110110;
            8'hFC: return 10'b0011111000;
            8'hF7: return 10'b1110101000;
            8'hFB: return 10'b1101101000;
            8'hFD: return 10'b1011101000;
            8'hFE: return 10'b0111101000;
            default: return 10'b0;
        endcase
    endfunction

    // Each unbalanced sub-block is picked so the running sum swings back across zero.
    function automatic logic [9:0] refEncode(input logic [7:0] d, input logic k, input bit rdPos);
        int         rs, d6, d4;
        logic [5:0] c6;
        logic [3:0] c4;
        logic [4:0] x;
        logic [2:0] y;
        logic [9:0] kc;
        x = d[4:0];
        y = d[7:5];
        if (k) begin
            kc = kTab(d);
            if (kc == 10'b0) kc = kTab(8'hBC);
            return rdPos ? ~kc : kc;
        end
        rs = rdPos ? 1 : -1;
        c6 = T6[x];
        d6 = 2 * $countones(c6) - 6;
        if (d6 != 0) begin
            if ((rs < 0) != (d6 > 0)) c6 = ~c6;
        end else if (x == 5'd7 && rs > 0) c6 = ~c6;
        rs += 2 * $countones(c6) - 6;
        if (y == 3'd7)
            c4 = ((rs < 0 && (x == 17 || x == 18 || x == 20)) ||
                  (rs > 0 && (x == 11 || x == 13 || x == 14))) ? 4'b0111 : 4'b1110;
        else
            c4 = T4[y];
        d4 = 2 * $countones(c4) - 4;
        if (d4 != 0) begin
            if ((rs < 0) != (d4 > 0)) c4 = ~c4;
        end else if (y == 3'd3 && rs > 0) c4 = ~c4;
        return {c6, c4};
    endfunction

    // Model state, owned by the monitor below.
    int         edgeCnt = 0;
    ent_t       q[$];
    ent_t       h;
    ent_t       newEnt;
    int         rds = -1;
    int         curBeat = 0;
    logic [9:0] curSym = '0;
    logic       curIdle = 1'b0;
    logic       curKErr = 1'b0;
    logic [SW-1:0] expSer;
    int         lineSum = -1;
    int         runLen = 0;
    logic       lastBit = 1'b0;
    int         maxRun, maxAbs;
    logic       sawFull = 1'b0;
    logic       b;

    always @(posedge i_Clk) begin
        if (i_rst) edgeCnt = 0;
        else       edgeCnt++;
    end

    always @(negedge i_Clk) begin
        if (i_rst) begin
            q.delete();
            rds     = -1;
            lineSum = -1;
            runLen  = 0;
            lastBit = 1'b0;
        end else if (edgeCnt > 0) begin
            curBeat = (edgeCnt - 1) % BEATS;
            if (curBeat == 0) begin
                if (q.size() > 0 && q[0].acc < edgeCnt) begin
                    h       = q.pop_front();
                    curIdle = 1'b0;
                    curSym  = refEncode(h.d, h.k, rds > 0);
                    curKErr = h.k && (kTab(h.d) == 10'b0);
                end else begin
                    curIdle = 1'b1;
                    curSym  = refEncode(8'hBC, 1'b1, rds > 0);
                    curKErr = 1'b0;
                end
                rds += 2 * $countones(curSym) - 10;
            end
            for (int i = 0; i < SW; i++) expSer[SW-1-i] = curSym[9 - curBeat*SW - i];
            checkOutput("symStart", o_Sym_Start, curBeat == 0);
            checkOutput("tenB", o_10B, curSym);
            checkOutput("rd", o_RD, rds > 0);
            checkOutput("idle", o_Idle, curIdle);
            checkOutput("serData", o_Ser_Data, expSer);
            checkOutput("ready", bus.o_Ready, q.size() != DEPTH);
`ifdef ENC8B10B_KCHAR_EN
            checkOutput("kErr", o_K_Err, (curBeat == 0) && curKErr);
`endif
            if (!bus.o_Ready) sawFull = 1'b1;
            maxRun = 0;
            maxAbs = 0;
            for (int i = 0; i < SW; i++) begin
                b = o_Ser_Data[SW-1-i];
                runLen  = (b == lastBit) ? runLen + 1 : 1;
                lastBit = b;
                lineSum += b ? 1 : -1;
                if (runLen > maxRun) maxRun = runLen;
                if (lineSum > maxAbs) maxAbs = lineSum;
                if (-lineSum > maxAbs) maxAbs = -lineSum;
            end
            checkOutput("runLenMax5", maxRun <= 5, 1'b1);
            checkOutput("rdsBound3", maxAbs <= 3, 1'b1);
        end
        if (!i_rst && bus.i_Valid && bus.o_Ready) begin
            newEnt.d   = bus.i_Data;
`ifdef ENC8B10B_KCHAR_EN
            newEnt.k   = bus.i_K;
`else
            newEnt.k   = 1'b0;
`endif
            newEnt.acc = edgeCnt + 1;
            q.push_back(newEnt);
        end
    end

    task automatic applyStimulus(input int cycles, input int validPct);
        for (int i = 0; i < cycles; i++) begin
            bus.i_Valid = ($urandom_range(99) < validPct);
            bus.i_Data  = 8'($urandom);
`ifdef ENC8B10B_KCHAR_EN
            bus.i_K     = ($urandom_range(7) == 0);
`endif
            @(posedge i_Clk);
            #1;
        end
        bus.i_Valid = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] d, input logic k);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        bus.i_Data  = d;
        bus.i_Valid = 1'b1;
`ifdef ENC8B10B_KCHAR_EN
        bus.i_K     = k;
`else
        if (k) $display("[TB] note: K flag ignored in this build");
`endif
        while (!got && n < 100) begin
            @(negedge i_Clk);
            got = bus.o_Ready;
            @(posedge i_Clk);
            #1;
            n++;
        end
        bus.i_Valid = 1'b0;
        checkOutput("sendAccepted", got, 1'b1);
    endtask

    logic found;

    initial begin
        bus.i_Valid = 1'b0;
        bus.i_Data  = 8'h00;
`ifdef ENC8B10B_KCHAR_EN
        bus.i_K     = 1'b0;
`endif
        #1 i_rst = 1'b1;
        #1;
        checkOutput("rstSer", o_Ser_Data, 0);
        checkOutput("rstTenB", o_10B, 0);
        checkOutput("rstRd", o_RD, 0);
        checkOutput("rstReady", bus.o_Ready, 0);
        repeat (3) @(posedge i_Clk);
        #1 i_rst = 1'b0;

        checkOutput("pinD0.3m", refEncode(8'h60, 1'b0, 1'b0), 10'b1001110011);
        checkOutput("pinD0.3p", refEncode(8'h60, 1'b0, 1'b1), 10'b0110001100);
        checkOutput("pinD17.7m", refEncode(8'hF1, 1'b0, 1'b0), 10'b1000110111);
        checkOutput("pinD21.5m", refEncode(8'hB5, 1'b0, 1'b0), 10'b1010101010);
        checkOutput("pinD11.7p", refEncode(8'hEB, 1'b0, 1'b1), 10'b1101001000);
        checkOutput("pinK28.5p", refEncode(8'hBC, 1'b1, 1'b1), 10'b1100000101);

        @(posedge i_Clk);
        #1;
        checkOutput("firstIdleTenB", o_10B, 10'b0011111010);
        checkOutput("firstIdleRd", o_RD, 1'b1);
        checkOutput("firstIdleFlag", o_Idle, 1'b1);
        checkOutput("firstReady", bus.o_Ready, 1'b1);
        repeat (BEATS) @(posedge i_Clk);
        #1;
        checkOutput("secondIdleTenB", o_10B, 10'b1100000101);
        checkOutput("secondIdleRd", o_RD, 1'b0);

        applyStimulus(20, 0);
        sendByte(8'h60, 1'b0);
        sendByte(8'h60, 1'b0);
        sendByte(8'hF1, 1'b0);
        sendByte(8'hB5, 1'b0);
        applyStimulus(30, 0);
        applyStimulus(300, 40);
        sawFull = 1'b0;
        applyStimulus(60, 100);
        checkOutput("sawFull", sawFull, 1'b1);

        sendByte(8'h3A, 1'b0);
        sendByte(8'h5B, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge i_Clk);
            #1;
            if (edgeCnt > 0 && curBeat == BEATS - 1 && !curIdle) found = 1'b1;
        end
        checkOutput("midSymbolFound", found, 1'b1);
        #2 i_rst = 1'b1;
        #1;
        checkOutput("midRstSer", o_Ser_Data, 0);
        checkOutput("midRstTenB", o_10B, 0);
        checkOutput("midRstRd", o_RD, 0);
        checkOutput("midRstStart", o_Sym_Start, 0);
        checkOutput("midRstIdle", o_Idle, 0);
        checkOutput("midRstReady", bus.o_Ready, 0);
        @(posedge i_Clk);
        #1;
        @(posedge i_Clk);
        #1 i_rst = 1'b0;
        @(posedge i_Clk);
        #1;
        checkOutput("postRstTenB", o_10B, 10'b0011111010);
        checkOutput("postRstIdle", o_Idle, 1'b1);

        applyStimulus(200, 60);
`ifdef ENC8B10B_KCHAR_EN
        sendByte(8'hBC, 1'b1);
        sendByte(8'h00, 1'b1);
        applyStimulus(100, 50);
`endif
        applyStimulus(60, 0);
        checkOutput("drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
